// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
//   Shared definitions for the parametrised LIFO stack and for other
//   parametrised storage blocks in the exp labs.
//
//   Contents:
//     stack_op_e - 2-bit operation code decoded from {push, pop}
//                  OP_NONE / OP_POP / OP_PUSH / OP_REPL (replace-top)
//     cnt_width  - width of a counter that must hold 0..max_value inclusive
// ---------------------------------------------------------------------------
package stack_pkg;

    // Operation codes. The bit order matches the concatenation {push, pop},
    // so the raw request pair can be cast directly to this type.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } stack_op_e;

    // Bits needed to represent every value from 0 up to max_value inclusive.
    // Never returns less than 1 so a degenerate size still yields a legal vector.
    function automatic int cnt_width(input int max_value);
        if (max_value < 1) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage : stack_pkg

// File: rtl/stack_mem.sv
// ---------------------------------------------------------------------------
// stack_mem
//   DEPTH x WIDTH register file used as the storage array of param_stack.
//   One synchronous write port and one combinational read port. The array is
//   intentionally not reset; the owner tracks which entries are valid.
//
//   Parameters:
//     WIDTH - word width in bits
//     DEPTH - number of words
//     AW    - address width (may cover more than DEPTH words)
//
//   Ports:
//     clk    in   1      write clock (rising edge)
//     we     in   1      write enable
//     waddr  in   AW     write address
//     wdata  in   WIDTH  write data
//     raddr  in   AW     read address
//     rdata  out  WIDTH  read data, combinational; 0 for addresses >= DEPTH
// ---------------------------------------------------------------------------
module stack_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The owner only reads in-range addresses while the stack holds data, but
    // an empty stack presents count-1 (all ones) here, so out-of-range reads
    // are folded to zero instead of indexing past the array.
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule : stack_mem

// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack
//   Parametrised LIFO stack with occupancy count, a combinational peek of the
//   top entry, sticky overflow/underflow flags and a simultaneous push+pop
//   "replace-top" operation. Single clock domain, asynchronous active-high
//   reset.
//
//   Parameters:
//     WIDTH  - data word width in bits (>= 1)
//     DEPTH  - number of entries (>= 2)
//     CNT_W  - derived width of count, holds 0..DEPTH
//
//   Ports:
//     clk         in   1      clock, all state updates on rising edge
//     rst         in   1      asynchronous, active-high reset
//     push        in   1      push data_in this cycle
//     pop         in   1      pop the top entry this cycle
//     data_in     in   WIDTH  word to push
//     clear_err   in   1      synchronous clear of the sticky error flags
//     data_out    out  WIDTH  registered word removed by the last accepted pop
//     dout_valid  out  1      one-cycle strobe: data_out updated this cycle
//     top         out  WIDTH  combinational peek of the top entry, 0 if empty
//     count       out  CNT_W  number of valid entries, 0..DEPTH
//     full        out  1      count == DEPTH
//     empty       out  1      count == 0
//     overflow    out  1      sticky: a push was rejected
//     underflow   out  1      sticky: a pop was rejected
//     high_water  out  CNT_W  (STACK_WATERMARK_EN only) max count since reset
//
//   Configuration macro:
//     STACK_WATERMARK_EN - when defined, adds the high_water port and register.
//
//   Request semantics: push and pop are fire-and-forget requests sampled on
//   every rising edge; there is no ready. A request that cannot be honoured
//   (push while full, pop while empty) is dropped and recorded in the
//   matching sticky flag. push+pop on a non-empty stack pops the old top and
//   writes data_in in its place; on an empty stack it degrades to a plain
//   push and the pop half is reported as an underflow.
// ---------------------------------------------------------------------------
module param_stack
    import stack_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 5,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef STACK_WATERMARK_EN
    ,
    output logic [CNT_W-1:0] high_water
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    stack_op_e        op;
    logic [CNT_W-1:0] top_idx;
    logic [CNT_W-1:0] count_next;
    logic             mem_we;
    logic [CNT_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             pop_ok;
    logic             push_rej;
    logic             pop_rej;

    assign op      = stack_op_e'({push, pop});
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // Wraps to all ones when empty; the memory returns 0 for that address and
    // top is masked anyway.
    assign top_idx = count - ONE_C;
    assign top     = empty ? '0 : mem_rdata;

    // -----------------------------------------------------------------------
    // Operation decode against the pre-edge count.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = count;
        count_next = count;
        pop_ok     = 1'b0;
        push_rej   = 1'b0;
        pop_rej    = 1'b0;
        case (op)
            OP_PUSH: begin
                if (full) begin
                    push_rej = 1'b1;
                end else begin
                    mem_we     = 1'b1;
                    count_next = count + ONE_C;
                end
            end
            OP_POP: begin
                if (empty) begin
                    pop_rej = 1'b1;
                end else begin
                    pop_ok     = 1'b1;
                    count_next = count - ONE_C;
                end
            end
            OP_REPL: begin
                mem_we = 1'b1;
                if (empty) begin
                    // Behaves as a plain push into slot 0.
                    pop_rej    = 1'b1;
                    count_next = count + ONE_C;
                end else begin
                    // Old top is read combinationally this cycle and captured
                    // into data_out at the same edge that overwrites it.
                    pop_ok    = 1'b1;
                    mem_waddr = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (CNT_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_in),
        .raddr (top_idx),
        .rdata (mem_rdata)
    );

    // -----------------------------------------------------------------------
    // Count, output registers and sticky flags.
    // A new error in the same cycle as clear_err keeps its flag set.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            data_out   <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_next;
            dout_valid <= pop_ok;
            if (pop_ok) begin
                data_out <= mem_rdata;
            end
            overflow  <= push_rej | (overflow  & ~clear_err);
            underflow <= pop_rej  | (underflow & ~clear_err);
        end
    end

`ifdef STACK_WATERMARK_EN
    // Tracks the post-edge count so the mark moves on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water <= '0;
        end else if (count_next > high_water) begin
            high_water <= count_next;
        end
    end
`endif

endmodule : param_stack

// File: tb/tb_param_stack.sv
// ---------------------------------------------------------------------------
// tb_param_stack
//   Self-checking bench for param_stack (WIDTH=4, DEPTH=5). A queue-based
//   reference model tracks the expected stack contents, outputs and flags;
//   exp_q holds the words the model expects to see popped, in order.
// ---------------------------------------------------------------------------
module tb_param_stack;

    localparam int WIDTH = 4;
    localparam int DEPTH = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // -----------------------------------------------------------------------
    // DUT signals
    // -----------------------------------------------------------------------
    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clear_err;
    logic [WIDTH-1:0] data_out;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
`ifdef STACK_WATERMARK_EN
    logic [CNT_W-1:0] high_water;
`endif

    param_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .clear_err  (clear_err),
        .data_out   (data_out),
        .dout_valid (dout_valid),
        .top        (top),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef STACK_WATERMARK_EN
        ,
        .high_water (high_water)
`endif
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model and scoreboard
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] m_stk[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;
    int               m_hw;

    int n_tests;
    int n_fail;

    task automatic model_reset();
        m_stk.delete();
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_hw    = 0;
    endtask

    task automatic model_step(input logic p, input logic q,
                              input logic [WIDTH-1:0] d, input logic c);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_valid = 1'b0;
        if (p && q) begin
            if (m_stk.size() == 0) begin
                m_stk.push_back(d);
                m_unf = 1'b1;
            end else begin
                m_dout = m_stk[$];
                m_valid = 1'b1;
                m_stk[m_stk.size() - 1] = d;
                exp_q.push_back(m_dout);
            end
        end else if (p) begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else m_stk.push_back(d);
        end else if (q) begin
            if (m_stk.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_dout = m_stk.pop_back();
                m_valid = 1'b1;
                exp_q.push_back(m_dout);
            end
        end
        if (m_stk.size() > m_hw) m_hw = m_stk.size();
    endtask

    // -----------------------------------------------------------------------
    // Driver: apply one request for one edge, advance the model, then sample
    // 1 time unit after the edge with inputs returned to idle.
    // -----------------------------------------------------------------------
    task automatic drive(input logic p, input logic q,
                         input logic [WIDTH-1:0] d, input logic c);
        push      = p;
        pop       = q;
        data_in   = d;
        clear_err = c;
        @(posedge clk);
        model_step(p, q, d, c);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        n_tests++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || top !== '0 ||
            data_out !== '0 || dout_valid !== 1'b0 || overflow !== 1'b0 ||
            underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: count=%0d empty=%b full=%b top=%0d dout=%0d dv=%b ovf=%b unf=%b, want 0 1 0 0 0 0 0 0",
                     count, empty, full, top, data_out, dout_valid, overflow, underflow);
        end
`ifdef STACK_WATERMARK_EN
        n_tests++;
        if (high_water !== '0) begin
            n_fail++;
            $display("FAIL reset_hw: high_water=%0d want 0", high_water);
        end
`endif
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] vals [5];
        vals = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd5};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, vals[i], 1'b0);
            n_tests++;
            if (count !== CNT_W'(i + 1) || top !== vals[i]) begin
                n_fail++;
                $display("FAIL fill_%0d: count=%0d top=%0d want %0d %0d",
                         i, count, top, i + 1, vals[i]);
            end
        end
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b0 || top !== 4'd5) begin
            n_fail++;
            $display("FAIL fill_full: full=%b ovf=%b top=%0d want 1 0 5",
                     full, overflow, top);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 4'd2, 1'b0);
        n_tests++;
        if (overflow !== 1'b1 || count !== CNT_W'(5) || top !== 4'd5) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b count=%0d top=%0d want 1 5 5",
                     overflow, count, top);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0 || count !== CNT_W'(5)) begin
            n_fail++;
            $display("FAIL overflow_clear: ovf=%b count=%0d want 0 5", overflow, count);
        end
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'd0, 1'b0);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (dout_valid !== 1'b1 || data_out !== e) begin
                n_fail++;
                $display("FAIL drain_%0d: dv=%b dout=%0d want 1 %0d", i, dout_valid, data_out, e);
            end
        end
        n_tests++;
        if (empty !== 1'b1 || data_out !== 4'd3) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b dout=%0d want 1 3", empty, data_out);
        end
        drive(1'b0, 1'b1, 4'd0, 1'b0);
        n_tests++;
        if (underflow !== 1'b1 || dout_valid !== 1'b0 || data_out !== 4'd3 || count !== '0) begin
            n_fail++;
            $display("FAIL underflow: unf=%b dv=%b dout=%0d count=%0d want 1 0 3 0",
                     underflow, dout_valid, data_out, count);
        end
        // Hold: dout_valid must drop after a single strobe cycle.
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        n_tests++;
        if (underflow !== 1'b0 || dout_valid !== 1'b0 || data_out !== 4'd3) begin
            n_fail++;
            $display("FAIL underflow_clear: unf=%b dv=%b dout=%0d want 0 0 3",
                     underflow, dout_valid, data_out);
        end
    endtask

    task automatic test_replace();
        drive(1'b1, 1'b0, 4'd3, 1'b0);
        drive(1'b1, 1'b0, 4'd7, 1'b0);
        drive(1'b1, 1'b1, 4'd4, 1'b0);
        n_tests++;
        if (data_out !== 4'd7 || dout_valid !== 1'b1 || count !== CNT_W'(2) || top !== 4'd4) begin
            n_fail++;
            $display("FAIL replace: dout=%0d dv=%b count=%0d top=%0d want 7 1 2 4",
                     data_out, dout_valid, count, top);
        end
        drive(1'b0, 1'b1, 4'd0, 1'b0);
        n_tests++;
        if (data_out !== 4'd4 || dout_valid !== 1'b1 || top !== 4'd3) begin
            n_fail++;
            $display("FAIL replace_pop: dout=%0d dv=%b top=%0d want 4 1 3",
                     data_out, dout_valid, top);
        end
        drive(1'b0, 1'b1, 4'd0, 1'b0);
        // Replace-top while full keeps count at DEPTH and raises no overflow.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 4'(i + 10), 1'b0);
        drive(1'b1, 1'b1, 4'd6, 1'b0);
        n_tests++;
        if (data_out !== 4'd14 || count !== CNT_W'(DEPTH) || top !== 4'd6 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_full: dout=%0d count=%0d top=%0d ovf=%b want 14 5 6 0",
                     data_out, count, top, overflow);
        end
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 4'd0, 1'b0);
        exp_q.delete();
    endtask

    task automatic test_replace_empty();
        drive(1'b1, 1'b1, 4'd14, 1'b0);
        n_tests++;
        if (count !== CNT_W'(1) || top !== 4'd14 || underflow !== 1'b1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_empty: count=%0d top=%0d unf=%b dv=%b want 1 14 1 0",
                     count, top, underflow, dout_valid);
        end
        drive(1'b0, 1'b1, 4'd0, 1'b0);
        n_tests++;
        if (data_out !== 4'd14 || empty !== 1'b1 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL replace_empty_pop: dout=%0d empty=%b dv=%b want 14 1 1",
                     data_out, empty, dout_valid);
        end
        // A rejected push in the same cycle as clear_err keeps overflow set.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
        drive(1'b1, 1'b0, 4'd8, 1'b1);
        n_tests++;
        if (overflow !== 1'b1 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_vs_new: ovf=%b unf=%b want 1 0", overflow, underflow);
        end
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 1'b0);   // underflow left set for the reset test
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 4'd11, 1'b0);
        drive(1'b1, 1'b0, 4'd12, 1'b0);
        drive(1'b1, 1'b0, 4'd13, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 4'd2, 1'b0);
        n_tests++;
        if (count !== CNT_W'(3) || underflow !== 1'b1 || data_out !== 4'd13) begin
            n_fail++;
            $display("FAIL pre_reset: count=%0d unf=%b dout=%0d want 3 1 13",
                     count, underflow, data_out);
        end
        // Assert rst between edges and check before the next edge.
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (count !== '0 || empty !== 1'b1 || data_out !== '0 || overflow !== 1'b0 ||
            underflow !== 1'b0 || dout_valid !== 1'b0 || top !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d empty=%b dout=%0d ovf=%b unf=%b dv=%b top=%0d want 0 1 0 0 0 0 0",
                     count, empty, data_out, overflow, underflow, dout_valid, top);
        end
`ifdef STACK_WATERMARK_EN
        n_tests++;
        if (high_water !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_hw: high_water=%0d want 0", high_water);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] exp_top;
        int bias;
        logic p, q, c;
        for (int i = 0; i < 400; i++) begin
            // Alternate push-heavy and pop-heavy phases to hit full and empty.
            bias = ((i / 25) % 2 == 0) ? 75 : 25;
            p = ($urandom_range(0, 99) < bias);
            q = ($urandom_range(0, 99) >= bias);
            c = ($urandom_range(0, 9) == 0);
            drive(p, q, 4'($urandom_range(0, 15)), c);
            exp_top = (m_stk.size() > 0) ? m_stk[$] : '0;
            n_tests++;
            if (count !== CNT_W'(m_stk.size()) || top !== exp_top ||
                full !== (m_stk.size() == DEPTH) || empty !== (m_stk.size() == 0) ||
                overflow !== m_ovf || underflow !== m_unf || dout_valid !== m_valid ||
                data_out !== m_dout) begin
                n_fail++;
                $display("FAIL random_%0d: count=%0d top=%0d full=%b empty=%b ovf=%b unf=%b dv=%b dout=%0d want %0d %0d %b %b %b %b %b %0d",
                         i, count, top, full, empty, overflow, underflow, dout_valid, data_out,
                         m_stk.size(), exp_top, (m_stk.size() == DEPTH), (m_stk.size() == 0),
                         m_ovf, m_unf, m_valid, m_dout);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_tests++;
                if (dout_valid !== 1'b1 || data_out !== e) begin
                    n_fail++;
                    $display("FAIL random_pop_%0d: dv=%b dout=%0d want 1 %0d", i, dout_valid, data_out, e);
                end
            end
`ifdef STACK_WATERMARK_EN
            n_tests++;
            if (high_water !== CNT_W'(m_hw)) begin
                n_fail++;
                $display("FAIL random_hw_%0d: high_water=%0d want %0d", i, high_water, m_hw);
            end
`endif
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and final report
    // -----------------------------------------------------------------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        clear_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_replace();
        test_replace_empty();
        test_mid_reset();
        test_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_param_stack
